// File: rtl/instr_encoder.sv
// instr_encoder: builds 32-bit MIPS words for a 28-instruction subset
// from a mnemonic index and operand fields, and streams them into
// instruction memory through a small FIFO.
//
// Ports
//   clk, rst_n          clock (rising edge), async active-low reset
//   start               restart pulse: flush, clear counters/errors, go RUN
//   in_valid/in_ready   request handshake; in_last marks the final request
//   in_mn               mnemonic index (0..27 legal, 28..31 illegal)
//   in_rs..in_sh        register / shift-amount fields
//   in_imm, in_tgt      I-type immediate, J-type target
//   im_we/im_ready      IM write handshake
//   im_addr, im_wdata   IM word address and encoded word
//   done                one-cycle pulse once the program is written
//   err_illegal         sticky: illegal mnemonic seen since start
//   err_full            sticky: IM capacity exhausted
//   word_cnt            words written since start
//
// state | meaning
// IDLE  | waiting for start
// RUN   | accepting requests
// DRAIN | last request taken, emptying encoder stage and FIFO
// DONE  | done pulse, back to IDLE next cycle
module instr_encoder #(
  parameter int ADDR_W     = 10,
  parameter int BASE_ADDR  = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [4:0]        in_mn,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_sh,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_tgt,
  output logic              im_we,
  input  logic              im_ready,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              done,
  output logic              err_illegal,
  output logic              err_full,
  output logic [ADDR_W:0]   word_cnt
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   CNT_LAST = {1'b0, {ADDR_W{1'b1}}};
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [PW-1:0]     PTR_ONE  = PW'(1);
  localparam logic [PW:0]       CNT_FULL = (PW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  // bit 32 = legal flag, bits 31:0 = encoded word
  function automatic logic [32:0] encode(
    input logic [4:0]  mn, rs, rt, rd, sh,
    input logic [15:0] imm,
    input logic [25:0] tgt
  );
    logic [32:0] r;
    r = {1'b1, 32'h0};
    case (mn)
      5'd0:  r[31:0] = {6'h00, rs, rt, rd, 5'd0, 6'h20};
      5'd1:  r[31:0] = {6'h00, rs, rt, rd, 5'd0, 6'h21};
      5'd2:  r[31:0] = {6'h00, rs, rt, rd, 5'd0, 6'h24};
      5'd3:  r[31:0] = {6'h00, 5'd0, rt, rd, sh, 6'h00};
      5'd4:  r[31:0] = {6'h00, 5'd0, rt, rd, sh, 6'h03};
      5'd5:  r[31:0] = {6'h00, 5'd0, rt, rd, sh, 6'h02};
      5'd6:  r[31:0] = {6'h00, rs, rt, rd, 5'd0, 6'h22};
      5'd7:  r[31:0] = {6'h00, rs, rt, rd, 5'd0, 6'h25};
      5'd8:  r[31:0] = {6'h00, rs, rt, rd, 5'd0, 6'h27};
      5'd9:  r[31:0] = {6'h00, rs, rt, rd, 5'd0, 6'h2A};
      5'd10: r[31:0] = {6'h00, rs, rt, rd, 5'd0, 6'h2B};
      5'd11: r[31:0] = {6'h00, rs, 15'd0, 6'h08};
      5'd12: r[31:0] = 32'h0000000C;
      5'd13: r[31:0] = {6'h00, rs, rt, 10'd0, 6'h1B};
      5'd14: r[31:0] = {6'h00, 10'd0, rd, 5'd0, 6'h12};
      5'd15: r[31:0] = {6'h08, rs, rt, imm};
      5'd16: r[31:0] = {6'h09, rs, rt, imm};
      5'd17: r[31:0] = {6'h0C, rs, rt, imm};
      5'd18: r[31:0] = {6'h0D, rs, rt, imm};
      5'd19: r[31:0] = {6'h23, rs, rt, imm};
      5'd20: r[31:0] = {6'h2B, rs, rt, imm};
      5'd21: r[31:0] = {6'h04, rs, rt, imm};
      5'd22: r[31:0] = {6'h05, rs, rt, imm};
      5'd23: r[31:0] = {6'h0A, rs, rt, imm};
      5'd24: r[31:0] = {6'h02, tgt};
      5'd25: r[31:0] = {6'h03, tgt};
      5'd26: r[31:0] = {6'h06, rs, 5'd0, imm};
      5'd27: r[31:0] = {6'h20, rs, rt, imm};
      default: r = '0;
    endcase
    return r;
  endfunction

  state_t        state;
  logic [31:0]   mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic          enc_valid;
  logic [31:0]   enc_word;
  logic [32:0]   enc_res;
  logic          fifo_full, fifo_empty, accept, wr_fire, push, cap_hit;

  assign enc_res = encode(in_mn, in_rs, in_rt, in_rd, in_sh, in_imm, in_tgt);

  always_comb begin
    fifo_full  = (count == CNT_FULL);
    fifo_empty = (count == '0);
    in_ready   = (state == RUN) & ~fifo_full & ~err_full;
    accept     = in_valid & in_ready;
    im_we      = ~fifo_empty & ~err_full;
    wr_fire    = im_we & im_ready;
    // The encoder stage may move into a full FIFO when the head leaves the same cycle.
    push       = enc_valid & (~fifo_full | wr_fire);
    cap_hit    = wr_fire & (word_cnt == CNT_LAST);
    im_wdata   = fifo_empty ? 32'h0 : mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= enc_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      enc_valid   <= 1'b0;
      enc_word    <= '0;
      im_addr     <= BASE;
      word_cnt    <= '0;
      done        <= 1'b0;
      err_illegal <= 1'b0;
      err_full    <= 1'b0;
    end else if (start) begin
      state       <= RUN;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      enc_valid   <= 1'b0;
      im_addr     <= BASE;
      word_cnt    <= '0;
      done        <= 1'b0;
      err_illegal <= 1'b0;
      err_full    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (cap_hit) begin
        // Final word of IM capacity: address stays put, everything still queued is dropped.
        err_full  <= 1'b1;
        word_cnt  <= word_cnt + CNT_ONE;
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        count     <= '0;
        enc_valid <= 1'b0;
        state     <= DONE;
        done      <= 1'b1;
      end else begin
        if (wr_fire) begin
          rd_ptr   <= rd_ptr + PTR_ONE;
          im_addr  <= im_addr + ADDR_ONE;
          word_cnt <= word_cnt + CNT_ONE;
        end
        if (push) wr_ptr <= wr_ptr + PTR_ONE;
        case ({push, wr_fire})
          2'b10:   count <= count + (PW+1)'(1);
          2'b01:   count <= count - (PW+1)'(1);
          default: count <= count;
        endcase
        if (accept) begin
          enc_valid <= enc_res[32];
          enc_word  <= enc_res[31:0];
          if (!enc_res[32]) err_illegal <= 1'b1;
        end else if (push) begin
          enc_valid <= 1'b0;
        end
        case (state)
          RUN:   if (accept && in_last) state <= DRAIN;
          DRAIN: if (fifo_empty && !enc_valid) begin
                   state <= DONE;
                   done  <= 1'b1;
                 end
          DONE:  state <= IDLE;
          default: state <= state;
        endcase
      end
    end
  end

endmodule
